// File: rtl/alu_seq_unit.sv
// alu_seq_unit: multi-cycle ALU with valid/ready request and response channels.
// Logic/add ops finish in one cycle; shifts step one bit per cycle; MUL is a 32-step shift-add.
module alu_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [4:0]       alu_op,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             illegal,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [4:0]       op_q;
    logic [WIDTH-1:0] work, mplr, acc;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] alu_res, sh_nxt, acc_nxt, exec_res;

    assign alu_res = alu_op == 5'd0 ? alu_a + alu_b :
                     alu_op == 5'd1 ? alu_a - alu_b :
                     alu_op == 5'd2 ? alu_a & alu_b :
                     alu_op == 5'd3 ? alu_a | alu_b :
                     alu_op == 5'd4 ? alu_a ^ alu_b :
                     alu_op == 5'd5 ? ~(alu_a | alu_b) :
                     {{(WIDTH-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
    assign sh_nxt   = op_q == 5'd7 ? work << 1 :
                      op_q == 5'd8 ? work >> 1 : {work[WIDTH-1], work[WIDTH-1:1]};
    assign acc_nxt  = acc + (mplr[0] ? work : '0);
    assign exec_res = op_q == 5'd10 ? acc_nxt : sh_nxt;

    assign req_ready  = state == IDLE;
    assign resp_valid = state == DONE;
    assign busy       = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= '0;
            work    <= '0;
            mplr    <= '0;
            acc     <= '0;
            cnt     <= '0;
            alu_out <= '0;
            zero    <= 1'b1;
            illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    op_q <= alu_op;
                    if (alu_op < 5'd7) begin
                        alu_out <= alu_res;
                        zero    <= alu_res == '0;
                        illegal <= 1'b0;
                        state   <= DONE;
                    end else if (alu_op < 5'd10) begin
                        work <= alu_a;
                        cnt  <= {1'b0, alu_b[CW-2:0]};
                        if (alu_b[CW-2:0] == '0) begin
                            alu_out <= alu_a;
                            zero    <= alu_a == '0;
                            illegal <= 1'b0;
                            state   <= DONE;
                        end else begin
                            state <= EXEC;
                        end
                    end else if (alu_op == 5'd10) begin
                        acc   <= '0;
                        work  <= alu_a;
                        mplr  <= alu_b;
                        cnt   <= CW'(WIDTH);
                        state <= EXEC;
                    end else begin
                        alu_out <= '0;
                        zero    <= 1'b1;
                        illegal <= 1'b1;
                        state   <= DONE;
                    end
                end
                EXEC: begin
                    // Shifts reuse work as the operand; MUL uses it as the multiplicand.
                    work <= op_q == 5'd10 ? work << 1 : sh_nxt;
                    acc  <= acc_nxt;
                    mplr <= mplr >> 1;
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        alu_out <= exec_res;
                        zero    <= exec_res == '0;
                        illegal <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: if (resp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: directed vectors with hand-computed results and latencies.
module tb_alu_seq_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] alu_a = '0;
    logic [31:0] alu_b = '0;
    logic [4:0]  alu_op = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] alu_out;
    logic        zero, illegal, busy;
    int checks = 0;
    int failures = 0;

    alu_seq_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .alu_out(alu_out), .zero(zero), .illegal(illegal),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                       input logic [31:0] exp, input logic exp_zero, input logic exp_ill,
                       input int lat_exp, input string tag);
        int lat;
        @(negedge clk);
        chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
        alu_a = a; alu_b = b; alu_op = op; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        alu_a = $urandom; alu_b = $urandom; alu_op = 5'($urandom);
        lat = 1;
        while (!resp_valid && lat < 100) begin
            chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(lat_exp));
        chk({tag, "_alu_out"}, alu_out, exp);
        chk({tag, "_zero"}, {31'b0, zero}, {31'b0, exp_zero});
        chk({tag, "_illegal"}, {31'b0, illegal}, {31'b0, exp_ill});
        if (resp_ready) begin
            @(posedge clk);
            #1;
            chk({tag, "_resp_drop"}, {31'b0, resp_valid}, 32'd0);
            chk({tag, "_idle_ready"}, {31'b0, req_ready}, 32'd1);
            chk({tag, "_hold_out"}, alu_out, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        chk("rst_alu_out", alu_out, 32'd0);
        chk("rst_zero", {31'b0, zero}, 32'd1);
        chk("rst_illegal", {31'b0, illegal}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(32'd3, 32'd2, 5'd0, 32'd5, 1'b0, 1'b0, 1, "add");
        run(32'd3, 32'd2, 5'd1, 32'd1, 1'b0, 1'b0, 1, "sub");
        run(32'd3, 32'd2, 5'd2, 32'd2, 1'b0, 1'b0, 1, "and");
        run(32'd3, 32'd2, 5'd3, 32'd3, 1'b0, 1'b0, 1, "or");
        run(32'd3, 32'd2, 5'd4, 32'd1, 1'b0, 1'b0, 1, "xor");
        run(32'd3, 32'd2, 5'd5, 32'hFFFFFFFC, 1'b0, 1'b0, 1, "nor");
        run(32'd3, 32'd2, 5'd6, 32'd0, 1'b1, 1'b0, 1, "slt_false");
        run(32'hFFFFFFFF, 32'd1, 5'd6, 32'd1, 1'b0, 1'b0, 1, "slt_signed");
        run(32'd0, 32'd1, 5'd1, 32'hFFFFFFFF, 1'b0, 1'b0, 1, "sub_wrap");

        run(32'd1, 32'd31, 5'd7, 32'h80000000, 1'b0, 1'b0, 32, "sll31");
        run(32'h80000000, 32'd4, 5'd9, 32'hF8000000, 1'b0, 1'b0, 5, "sra4");
        run(32'h80000000, 32'd4, 5'd8, 32'h08000000, 1'b0, 1'b0, 5, "srl4");
        run(32'h12345678, 32'hFFFFFFE0, 5'd7, 32'h12345678, 1'b0, 1'b0, 1, "shift0");

        run(32'd7, 32'd6, 5'd10, 32'd42, 1'b0, 1'b0, 33, "mul_7x6");
        run(32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10, 32'd1, 1'b0, 1'b0, 33, "mul_ones");
        run(32'h10000, 32'h10000, 5'd10, 32'd0, 1'b1, 1'b0, 33, "mul_ovf");

        resp_ready = 1'b0;
        run(32'd9, 32'd9, 5'd15, 32'd0, 1'b1, 1'b1, 1, "illegal");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req_valid = i[0];
            alu_a = 32'd3; alu_b = 32'd2; alu_op = 5'd0;
            chk("bp_resp_valid", {31'b0, resp_valid}, 32'd1);
            chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
            chk("bp_alu_out", alu_out, 32'd0);
            chk("bp_flags", {30'b0, zero, illegal}, 32'd3);
        end
        @(negedge clk);
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_resp", {31'b0, resp_valid}, 32'd0);
        chk("bp_release_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("bp_not_queued", {31'b0, busy}, 32'd0);
        chk("bp_keep_illegal", {31'b0, illegal}, 32'd1);

        @(negedge clk);
        alu_a = 32'd7; alu_b = 32'd6; alu_op = 5'd10; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        chk("mid_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_resp", {31'b0, resp_valid}, 32'd0);
        chk("mid_rst_out", alu_out, 32'd0);
        chk("mid_rst_zero", {31'b0, zero}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run(32'd3, 32'd2, 5'd0, 32'd5, 1'b0, 1'b0, 1, "add_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
